mem_stage: RTL

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It accepts one instruction per handshake from EXE and, for loads and stores, waits for the data-SRAM response (`data_ok`/`rdata`). It aligns and extends load data, then forwards the final result, exception flags and CSR fields to WB. It also drops responses that belong to flushed instructions, holds read data while WB stalls, and drives the forwarding/stall buses back to ID and EXE.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_load_align.sv | 21 ++
 rtl/mem_stage.sv | 80 ++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, field layouts and load-type encoding for the memory stage
package mem_stage_pkg;
  localparam int EXE_TO_MEM_W = 166;
  localparam int MEM_TO_WB_W = 189;
  localparam int ADDR_LO_W = 2;
  typedef struct packed {
    logic b;
    logic bu;
    logic h;
    logic hu;
    logic w;
  } ld_t;
  typedef struct packed {
    logic res_from_mem;
    logic gr_we;
    logic [4:0] dest;
    logic [31:0] wdata;
    logic [31:0] pc;
    ld_t ld;
    logic csr_re;
    logic csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [13:0] csr_num;
    logic syscall;
    logic ertn;
    logic rdcntvh;
    logic rdcntvl;
    logic brk;
    logic ine;
    logic intr;
    logic adef;
    logic ale;
    logic req;
  } exe_to_mem_t;
  function automatic logic has_exc(exe_to_mem_t e);
    return e.syscall | e.brk | e.ine | e.intr | e.adef | e.ale;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects and extends the byte/halfword addressed by a load
module mem_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic        ld_b,
  input  logic        ld_bu,
  input  logic        ld_h,
  input  logic        ld_hu,
  input  logic        ld_w,
  output logic [31:0] result
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  assign result = ld_w  ? rdata :
                  ld_b  ? {{24{b[7]}}, b} :
                  ld_bu ? {24'b0, b} :
                  ld_h  ? {{16{h[15]}}, h} :
                  ld_hu ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    EXE_to_MEM_valid,
  input  logic [EXE_TO_MEM_W-1:0] EXE_to_MEM_bus,
  input  logic                    WB_allow,
  input  logic                    WB_exception,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic                    MEM_allow,
  output logic                    MEM_to_WB_valid,
  output logic [MEM_TO_WB_W-1:0]  MEM_to_WB_bus,
  output logic [4:0]              MEM_dest_bus,
  output logic [31:0]             MEM_value_bus,
  output logic                    MEM_load_bus,
  output logic                    MEM_exception,
  output logic                    MEM_csr_re_bus
);
  exe_to_mem_t exe_bus, bus_r;
  logic mem_valid, rdata_buf_valid, have_data, mem_go, leave, handover, wait_st, drop_hit;
  logic [31:0] rdata_buf, rdata, load_res, final_result;
  logic [1:0] drop_cnt;
  logic [2:0] cnt_sum;
  logic unused_cnt;
  assign exe_bus = EXE_to_MEM_bus;
  assign unused_cnt = bus_r.rdcntvh ^ bus_r.rdcntvl;
  assign drop_hit = data_sram_data_ok & (drop_cnt != 2'd0);
  assign have_data = rdata_buf_valid | (data_sram_data_ok & (drop_cnt == 2'd0));
  assign mem_go = ~bus_r.req | have_data;
  assign MEM_allow = ~mem_valid | (mem_go & WB_allow);
  assign MEM_to_WB_valid = mem_valid & mem_go;
  assign leave = MEM_to_WB_valid & WB_allow;
  assign handover = EXE_to_MEM_valid & MEM_allow;
  assign wait_st = mem_valid & bus_r.req & ~have_data;
  // every request orphaned by a flush owes one response that must be swallowed
  assign cnt_sum = {1'b0, drop_cnt} - {2'b0, drop_hit}
                 + (WB_exception ? {2'b0, wait_st} + {2'b0, handover & exe_bus.req} : 3'd0);
  assign rdata = rdata_buf_valid ? rdata_buf : data_sram_rdata;
  mem_load_align u_align (
    .rdata(rdata),
    .addr(bus_r.wdata[1:0]),
    .ld_b(bus_r.ld.b),
    .ld_bu(bus_r.ld.bu),
    .ld_h(bus_r.ld.h),
    .ld_hu(bus_r.ld.hu),
    .ld_w(bus_r.ld.w),
    .result(load_res)
  );
  assign final_result = (bus_r.res_from_mem & ~has_exc(bus_r)) ? load_res : bus_r.wdata;
  assign MEM_to_WB_bus = {bus_r.gr_we, bus_r.dest, final_result, bus_r.pc,
                          bus_r.csr_re, bus_r.csr_we, bus_r.csr_wmask, bus_r.csr_wvalue, bus_r.csr_num,
                          bus_r.syscall, bus_r.ertn, bus_r.brk, bus_r.ine, bus_r.intr, bus_r.adef, bus_r.ale,
                          bus_r.wdata};
  assign MEM_dest_bus = (mem_valid & bus_r.gr_we) ? bus_r.dest : 5'd0;
  assign MEM_value_bus = final_result;
  assign MEM_load_bus = mem_valid & bus_r.res_from_mem & ~mem_go;
  assign MEM_exception = mem_valid & (has_exc(bus_r) | bus_r.ertn);
  assign MEM_csr_re_bus = mem_valid & bus_r.csr_re;
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      bus_r <= '0;
      rdata_buf <= 32'd0;
      rdata_buf_valid <= 1'b0;
      drop_cnt <= 2'd0;
    end else begin
      mem_valid <= WB_exception ? 1'b0 : MEM_allow ? EXE_to_MEM_valid : mem_valid;
      if (handover) bus_r <= exe_bus;
      if (WB_exception | leave) rdata_buf_valid <= 1'b0;
      else if (mem_valid & bus_r.req & ~rdata_buf_valid & data_sram_data_ok & (drop_cnt == 2'd0)) begin
        rdata_buf <= data_sram_rdata;
        rdata_buf_valid <= 1'b1;
      end
      drop_cnt <= (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
    end
  end
endmodule
